// File: rtl/scrod_trig_pkg.sv
// scrod_trig_pkg: shared FSM encodings and default parameters for the SCROD trigger responder.
package scrod_trig_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_FIRE    = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    localparam int DEF_ACK_HOLD        = 4;
    localparam int DEF_HOLDOFF         = 16;
    localparam int DEF_TRG_SYNC_STAGES = 2;
    localparam int DEF_CNT_W           = 32;

endpackage

// File: rtl/trig_in_sync.sv
// trig_in_sync: multi-flop synchroniser for the MTC TRG line plus rising-edge detector.
module trig_in_sync
    import scrod_trig_pkg::*;
#(
    parameter int STAGES = DEF_TRG_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trg_in,
    output logic trg_s,
    output logic trg_rise
);

    logic [STAGES-1:0] sync_q, sync_d, fill_q, fill_d;
    logic              trg_s_d_q, trg_s_d_d;

    // The edge flop is held high until the chain carries real samples, so a line
    // already high when reset is released is not mistaken for a new trigger.
    always_comb begin
        sync_d    = {sync_q[STAGES-2:0], trg_in};
        fill_d    = {fill_q[STAGES-2:0], 1'b1};
        trg_s     = sync_q[STAGES-1];
        trg_s_d_d = fill_q[STAGES-1] ? trg_s : 1'b1;
        trg_rise  = trg_s & ~trg_s_d_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            fill_q    <= '0;
            trg_s_d_q <= 1'b1;
        end else begin
            sync_q    <= sync_d;
            fill_q    <= fill_d;
            trg_s_d_q <= trg_s_d_d;
        end
    end

endmodule

// File: rtl/scrod_trig_resp.sv
// scrod_trig_resp: SCROD-side MTC trigger responder (ACK request, DIG_TRIG pulse, holdoff, statistics).
// Optional macro SCROD_TRIG_VETO_CNT_EN adds VETO_COUNT for rejected local triggers.
module scrod_trig_resp
    import scrod_trig_pkg::*;
#(
    parameter int ACK_HOLD        = DEF_ACK_HOLD,
    parameter int HOLDOFF         = DEF_HOLDOFF,
    parameter int TRG_SYNC_STAGES = DEF_TRG_SYNC_STAGES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             CLK_42MHZ,
    input  logic             RESET_N,
    input  logic             TRG_IN,
    output logic             ACK_OUT,
    input  logic             LOCAL_TRIG,
    input  logic             LOCAL_TRIG_EN,
    input  logic             BUSY,
    output logic             DIG_TRIG,
    output logic [CNT_W-1:0] TRG_COUNT,
    output logic [CNT_W-1:0] ACK_COUNT,
`ifdef SCROD_TRIG_VETO_CNT_EN
    output logic [CNT_W-1:0] VETO_COUNT,
`endif
    output logic [1:0]       STATE
);

    localparam int TMAX = (ACK_HOLD > HOLDOFF) ? ACK_HOLD : HOLDOFF;
    localparam int TW   = $clog2(TMAX + 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ack_q, ack_d, dig_q, dig_d;
    logic [CNT_W-1:0] trg_cnt_q, trg_cnt_d, ack_cnt_q, ack_cnt_d;
    logic             trg_s, trg_rise, local_req, accept;

    trig_in_sync #(.STAGES(TRG_SYNC_STAGES)) u_sync (
        .clk     (CLK_42MHZ),
        .rst_n   (RESET_N),
        .trg_in  (TRG_IN),
        .trg_s   (trg_s),
        .trg_rise(trg_rise)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ack_d     = 1'b0;
        trg_cnt_d = trg_cnt_q;
        ack_cnt_d = ack_cnt_q;
        local_req = LOCAL_TRIG & LOCAL_TRIG_EN;
        accept    = (state_q == S_IDLE) & local_req & ~trg_rise & ~BUSY;
        case (state_q)
            S_IDLE: begin
                if (trg_rise) begin
                    state_d = S_FIRE;
                end else if (accept) begin
                    state_d   = S_REQ;
                    ack_d     = 1'b1;
                    ack_cnt_d = ack_cnt_q + CNT_W'(1);
                    timer_d   = TW'(ACK_HOLD - 1);
                end
            end
            S_REQ: begin
                if (trg_rise) begin
                    state_d = S_FIRE;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    ack_d   = 1'b1;
                    timer_d = timer_q - TW'(1);
                end
            end
            S_FIRE: begin
                trg_cnt_d = trg_cnt_q + CNT_W'(1);
                state_d   = S_HOLDOFF;
                timer_d   = TW'(HOLDOFF - 1);
            end
            default: begin
                if (timer_q != '0) timer_d = timer_q - TW'(1);
                else if (!trg_s && !BUSY) state_d = S_IDLE;
            end
        endcase
        dig_d = (state_d == S_FIRE);
    end

    always_ff @(posedge CLK_42MHZ) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            ack_q     <= 1'b0;
            dig_q     <= 1'b0;
            trg_cnt_q <= '0;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ack_q     <= ack_d;
            dig_q     <= dig_d;
            trg_cnt_q <= trg_cnt_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

`ifdef SCROD_TRIG_VETO_CNT_EN
    logic [CNT_W-1:0] veto_q, veto_d;

    // Rejected means requested outside REQ but not taken by IDLE.
    always_comb begin
        veto_d = (local_req && state_q != S_REQ && !accept) ? veto_q + CNT_W'(1) : veto_q;
    end

    always_ff @(posedge CLK_42MHZ) begin
        if (!RESET_N) veto_q <= '0;
        else          veto_q <= veto_d;
    end

    assign VETO_COUNT = veto_q;
`endif

    assign ACK_OUT   = ack_q;
    assign DIG_TRIG  = dig_q;
    assign TRG_COUNT = trg_cnt_q;
    assign ACK_COUNT = ack_cnt_q;
    assign STATE     = state_q;

endmodule

// File: doc/scrod_trig_resp.md
Name: scrod_trig_resp

Overview:
SCROD-side responder for the MTC trigger link. Raises ACK toward the MTC on an enabled local self-trigger and holds it for a bounded window. Synchronises the MTC's broadcast TRG line and converts its rising edge into a single-cycle digitizer trigger. Applies a holdoff afterwards and keeps accept/request statistics for slow-control readout.

Parameters:
ACK_HOLD, 4, cycles ACK_OUT stays high per request if no TRG arrives; must be ≥1
HOLDOFF, 16, minimum cycles in HOLDOFF after a fired trigger; must be ≥1
TRG_SYNC_STAGES, 2, synchroniser depth on TRG_IN; must be ≥2
CNT_W, 32, width of statistics counters

Ports:
CLK_42MHZ  in  1  system clock, all logic on rising edge
RESET_N  in  1  synchronous, active-low reset
TRG_IN  in  1  trigger line from MTC, asynchronous, held high ≥8 cycles per trigger
ACK_OUT  out  1  trigger request to MTC, registered
LOCAL_TRIG  in  1  local discriminator trigger, synchronous to CLK_42MHZ, level
LOCAL_TRIG_EN  in  1  enables local requests
BUSY  in  1  digitizer readout busy
DIG_TRIG  out  1  one-cycle trigger to digitizer, registered
TRG_COUNT  out  CNT_W  fired digitizer triggers
ACK_COUNT  out  CNT_W  ACK requests issued
STATE  out  2  current FSM state, for debug

Behaviour:
- Reset: when RESET_N is low at a clock edge, state=IDLE, sync flops=0, ACK_OUT=0, DIG_TRIG=0, both counters=0, timers=0. Reset mid-operation aborts at once; ACK_OUT is low in the cycle after that edge.
- Synchroniser: TRG_IN passes through TRG_SYNC_STAGES flops to give trg_s, then one more flop. trg_rise = trg_s & ~trg_s_d.
- FSM encoding: IDLE=0, REQ=1, FIRE=2, HOLDOFF=3.
- IDLE:
  - If trg_rise: go to FIRE.
  - Else if LOCAL_TRIG & LOCAL_TRIG_EN & ~BUSY: go to REQ, ACK_OUT<=1, ACK_COUNT+1, ack timer<=ACK_HOLD-1.
  - trg_rise has priority over a simultaneous local trigger; in that case there is no ACK and no ACK_COUNT increment.
- REQ:
  - ACK_OUT stays 1.
  - If trg_rise: go to FIRE, ACK_OUT<=0.
  - Else if timer==0: go to IDLE, ACK_OUT<=0.
  - Else timer-1.
  - LOCAL_TRIG is ignored; a new request needs a return to IDLE.
- FIRE:
  - DIG_TRIG=1 for exactly this one cycle.
  - TRG_COUNT+1.
  - Go to HOLDOFF with holdoff timer<=HOLDOFF-1.
- HOLDOFF:
  - ACK_OUT=0.
  - Decrement timer to 0.
  - Go to IDLE only when timer==0 & trg_s==0 & BUSY==0.
  - TRG_IN stuck high therefore never retriggers; a fresh rising edge is required.
- Latency:
  - LOCAL_TRIG accepted at edge N gives ACK_OUT high after edge N.
  - TRG_IN first sampled high at edge N gives DIG_TRIG high after edge N+TRG_SYNC_STAGES, i.e. N+2 by default.
- Counters are CNT_W-bit unsigned and wrap from 2^CNT_W-1 to 0 with no sticky flag.
- STATE reflects the registered state.

Optional Feature:
SCROD_TRIG_VETO_CNT_EN
- Defined: adds output VETO_COUNT (CNT_W). It increments on every cycle where LOCAL_TRIG & LOCAL_TRIG_EN is high and the trigger is not accepted: BUSY high, or state is FIRE or HOLDOFF, or a trg_rise pre-empts it in IDLE. Cycles in REQ do not count. Reset to 0; wraps.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package scrod_trig_pkg: FSM state encodings, default ACK_HOLD/HOLDOFF/TRG_SYNC_STAGES constants, CNT_W.
- One sub-module, trig_in_sync: parameterised synchroniser plus rising-edge detector, outputs trg_s and trg_rise, reset by RESET_N.

Test Plan:
- Reset: RESET_N=0 for 3 cycles with TRG_IN=1 and LOCAL_TRIG=1 -> all outputs 0, STATE=0; then RESET_N=1 with TRG_IN held high -> no DIG_TRIG, because a rising edge is needed.
- Local timeout: LOCAL_TRIG pulse at edge 10, TRG_IN=0 -> ACK_OUT high for exactly 4 cycles, ACK_COUNT=1, TRG_COUNT=0, back in IDLE.
- Full handshake: LOCAL_TRIG at edge 10, TRG_IN rises before edge 11 -> ACK_OUT drops after the FIRE transition; DIG_TRIG pulses 1 cycle after edge 13; TRG_COUNT=1.
- Holdoff/busy: after FIRE, hold TRG_IN high 30 cycles and BUSY high until cycle 40 -> no return to IDLE until both are low; LOCAL_TRIG pulses meanwhile give ACK_COUNT unchanged, and VETO_COUNT increments when the macro is defined.
- Priority: trg_rise and LOCAL_TRIG in the same IDLE cycle -> FIRE, ACK_OUT never high, ACK_COUNT unchanged.
- Wrap: preload counters with CNT_W=4 and 15 triggers, then one more -> TRG_COUNT=0.
